// File: rtl/bram_sync_tdp.sv
// bram_sync_tdp: single-clock true dual-port block RAM with per-byte write
// enables, a selectable write mode, 1- or 2-cycle read latency and a per-port
// read-valid strobe.
// Optional feature macro: BRAM_TDP_COLLISION_DETECT_EN adds the collision
// pulse and the saturating collision_count outputs.
module bram_sync_tdp #(
    parameter int unsigned RAM_DATA_WIDTH = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 4,
    parameter int unsigned RD_LATENCY     = 1,
    parameter string       WRITE_MODE     = "READ_FIRST"
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        a_en,
    input  logic                        a_wr,
    input  logic [RAM_DATA_WIDTH/8-1:0] a_be,
    input  logic [RAM_ADDR_WIDTH-1:0]   a_addr,
    input  logic [RAM_DATA_WIDTH-1:0]   a_din,
    output logic [RAM_DATA_WIDTH-1:0]   a_dout,
    output logic                        a_valid,
    input  logic                        b_en,
    input  logic                        b_wr,
    input  logic [RAM_DATA_WIDTH/8-1:0] b_be,
    input  logic [RAM_ADDR_WIDTH-1:0]   b_addr,
    input  logic [RAM_DATA_WIDTH-1:0]   b_din,
    output logic [RAM_DATA_WIDTH-1:0]   b_dout,
    output logic                        b_valid
`ifdef BRAM_TDP_COLLISION_DETECT_EN
    ,
    output logic                        collision,
    output logic [15:0]                 collision_count
`endif
);

    localparam int unsigned NB    = RAM_DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 1 << RAM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        WM_READ_FIRST,
        WM_WRITE_FIRST,
        WM_NO_CHANGE,
        WM_ILLEGAL
    } wmode_e;

    localparam wmode_e WMODE = (WRITE_MODE == "READ_FIRST")  ? WM_READ_FIRST  :
                               (WRITE_MODE == "WRITE_FIRST") ? WM_WRITE_FIRST :
                               (WRITE_MODE == "NO_CHANGE")   ? WM_NO_CHANGE   :
                                                               WM_ILLEGAL;

    // Elaboration-time parameter legality checks
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("bram_sync_tdp: RD_LATENCY must be 1 or 2");
    end
    if (WMODE == WM_ILLEGAL) begin : g_bad_mode
        $error("bram_sync_tdp: unknown WRITE_MODE");
    end
    if ((RAM_DATA_WIDTH % 8) != 0 || RAM_DATA_WIDTH == 0) begin : g_bad_width
        $error("bram_sync_tdp: RAM_DATA_WIDTH must be a non-zero multiple of 8");
    end

    logic [RAM_DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic [RAM_DATA_WIDTH-1:0] w_a_old, w_a_merge, w_a_rdata;
    logic [RAM_DATA_WIDTH-1:0] w_b_old, w_b_merge, w_b_rdata;
    logic                      w_a_wacc, w_b_wacc;
    logic                      w_a_upd, w_b_upd;

    logic [RAM_DATA_WIDTH-1:0] r_a_p1_data, r_b_p1_data;
    logic                      r_a_p1_vld, r_b_p1_vld;

    // Pre-write words, own-port merged words and dout update decision
    always_comb begin
        w_a_old   = r_mem[a_addr];
        w_b_old   = r_mem[b_addr];
        w_a_merge = w_a_old;
        w_b_merge = w_b_old;
        for (int unsigned i = 0; i < NB; i++) begin
            if (a_be[i]) w_a_merge[8*i +: 8] = a_din[8*i +: 8];
            if (b_be[i]) w_b_merge[8*i +: 8] = b_din[8*i +: 8];
        end
        w_a_wacc  = a_en & a_wr & (|a_be);
        w_b_wacc  = b_en & b_wr & (|b_be);
        w_a_upd   = a_en & ~(w_a_wacc & (WMODE == WM_NO_CHANGE));
        w_b_upd   = b_en & ~(w_b_wacc & (WMODE == WM_NO_CHANGE));
        w_a_rdata = (w_a_wacc && WMODE == WM_WRITE_FIRST) ? w_a_merge : w_a_old;
        w_b_rdata = (w_b_wacc && WMODE == WM_WRITE_FIRST) ? w_b_merge : w_b_old;
    end

    // Byte-wise memory write; port A is written last so it wins shared bytes
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (w_b_wacc && b_be[i]) r_mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
                if (w_a_wacc && a_be[i]) r_mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
            end
        end
    end

    // First read stage: captures read data and valid, holds data when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_p1_vld  <= 1'b0;
            r_b_p1_vld  <= 1'b0;
            r_a_p1_data <= '0;
            r_b_p1_data <= '0;
        end else begin
            r_a_p1_vld <= w_a_upd;
            r_b_p1_vld <= w_b_upd;
            if (w_a_upd) r_a_p1_data <= w_a_rdata;
            if (w_b_upd) r_b_p1_data <= w_b_rdata;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [RAM_DATA_WIDTH-1:0] r_a_p2_data, r_b_p2_data;
        logic                      r_a_p2_vld, r_b_p2_vld;

        // Output register stage; only valid slots overwrite the held word
        always_ff @(posedge clk) begin
            if (rst) begin
                r_a_p2_vld  <= 1'b0;
                r_b_p2_vld  <= 1'b0;
                r_a_p2_data <= '0;
                r_b_p2_data <= '0;
            end else begin
                r_a_p2_vld <= r_a_p1_vld;
                r_b_p2_vld <= r_b_p1_vld;
                if (r_a_p1_vld) r_a_p2_data <= r_a_p1_data;
                if (r_b_p1_vld) r_b_p2_data <= r_b_p1_data;
            end
        end

        assign a_dout  = r_a_p2_data;
        assign a_valid = r_a_p2_vld;
        assign b_dout  = r_b_p2_data;
        assign b_valid = r_b_p2_vld;
    end else begin : g_lat1
        assign a_dout  = r_a_p1_data;
        assign a_valid = r_a_p1_vld;
        assign b_dout  = r_b_p1_data;
        assign b_valid = r_b_p1_vld;
    end

`ifdef BRAM_TDP_COLLISION_DETECT_EN
    logic        w_coll;
    logic        r_collision;
    logic [15:0] r_coll_cnt;

    assign w_coll = a_en & b_en & (a_addr == b_addr) & (a_wr | b_wr);

    // Registered collision pulse and saturating event counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_collision <= 1'b0;
            r_coll_cnt  <= '0;
        end else begin
            r_collision <= w_coll;
            if (w_coll && r_coll_cnt != 16'hFFFF) r_coll_cnt <= r_coll_cnt + 16'd1;
        end
    end

    assign collision       = r_collision;
    assign collision_count = r_coll_cnt;
`endif

endmodule

// File: tb/tb_bram_sync_tdp.sv
// Scoreboard bench for bram_sync_tdp: three instances (latency/mode variants)
// share one stimulus stream; a reference memory predicts every dout update.
module tb_bram_sync_tdp;

    localparam int ND = 3;

    typedef struct {
        int          due;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0, a_wr = 1'b0, b_en = 1'b0, b_wr = 1'b0;
    logic [3:0]  a_be = '0, b_be = '0, a_addr = '0, b_addr = '0;
    logic [31:0] a_din = '0, b_din = '0;

    logic [31:0] d0a, d0b, d1a, d1b, d2a, d2b;
    logic        v0a, v0b, v1a, v1b, v2a, v2b;
    logic [31:0] dout [ND][2];
    logic        vld  [ND][2];

    // instance 0: latency 1 READ_FIRST, 1: latency 2 WRITE_FIRST, 2: latency 1 NO_CHANGE
    int LAT  [ND] = '{1, 2, 1};
    int MODE [ND] = '{0, 1, 2};

    int          cyc = 0;
    int          nchk = 0;
    int          nerr = 0;
    logic [31:0] mem_m [16];
    exp_t        q [ND][2][$];
    logic [31:0] last [ND][2];

    always #5 clk = ~clk;

`ifdef BRAM_TDP_COLLISION_DETECT_EN
    logic        c0, c1, c2;
    logic [15:0] k0, k1, k2;
    logic        exp_coll = 1'b0;
    logic [15:0] exp_cnt  = '0;
`endif

    bram_sync_tdp #(.RAM_DATA_WIDTH(32), .RAM_ADDR_WIDTH(4), .RD_LATENCY(1), .WRITE_MODE("READ_FIRST")) u_rf (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din), .a_dout(d0a), .a_valid(v0a),
        .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din), .b_dout(d0b), .b_valid(v0b)
`ifdef BRAM_TDP_COLLISION_DETECT_EN
        , .collision(c0), .collision_count(k0)
`endif
    );

    bram_sync_tdp #(.RAM_DATA_WIDTH(32), .RAM_ADDR_WIDTH(4), .RD_LATENCY(2), .WRITE_MODE("WRITE_FIRST")) u_wf (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din), .a_dout(d1a), .a_valid(v1a),
        .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din), .b_dout(d1b), .b_valid(v1b)
`ifdef BRAM_TDP_COLLISION_DETECT_EN
        , .collision(c1), .collision_count(k1)
`endif
    );

    bram_sync_tdp #(.RAM_DATA_WIDTH(32), .RAM_ADDR_WIDTH(4), .RD_LATENCY(1), .WRITE_MODE("NO_CHANGE")) u_nc (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din), .a_dout(d2a), .a_valid(v2a),
        .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din), .b_dout(d2b), .b_valid(v2b)
`ifdef BRAM_TDP_COLLISION_DETECT_EN
        , .collision(c2), .collision_count(k2)
`endif
    );

    always_comb begin
        dout[0][0] = d0a; dout[0][1] = d0b; vld[0][0] = v0a; vld[0][1] = v0b;
        dout[1][0] = d1a; dout[1][1] = d1b; vld[1][0] = v1a; vld[1][1] = v1b;
        dout[2][0] = d2a; dout[2][1] = d2b; vld[2][0] = v2a; vld[2][1] = v2b;
    end

    function automatic void chk(bit ok, string name, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] din, logic [3:0] be);
        logic [31:0] m;
        m = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) m[8*i +: 8] = din[8*i +: 8];
        return m;
    endfunction

    // What one port of one instance should present for an access at this edge
    function automatic void predict(int d, int p, logic en, logic wr, logic [3:0] be,
                                    logic [31:0] din, logic [31:0] old);
        bit          is_write;
        logic [31:0] data;
        exp_t        e;
        if (!en) return;
        is_write = wr && (be != 4'h0);
        if (is_write && MODE[d] == 2) return;
        data  = (is_write && MODE[d] == 1) ? merge(old, din, be) : old;
        e.due = cyc + LAT[d] - 1;
        e.d   = data;
        q[d][p].push_back(e);
    endfunction

    // Reference model: sees each edge's inputs, predicts outputs, updates memory
    always @(posedge clk) begin
        logic [31:0] old_a, old_b;
        cyc++;
        if (rst) begin
            for (int d = 0; d < ND; d++)
                for (int p = 0; p < 2; p++) begin
                    q[d][p].delete();
                    last[d][p] = '0;
                end
`ifdef BRAM_TDP_COLLISION_DETECT_EN
            exp_coll = 1'b0;
            exp_cnt  = '0;
`endif
        end else begin
            old_a = mem_m[a_addr];
            old_b = mem_m[b_addr];
            for (int d = 0; d < ND; d++) begin
                predict(d, 0, a_en, a_wr, a_be, a_din, old_a);
                predict(d, 1, b_en, b_wr, b_be, b_din, old_b);
            end
            if (b_en && b_wr) mem_m[b_addr] = merge(mem_m[b_addr], b_din, b_be);
            if (a_en && a_wr) mem_m[a_addr] = merge(mem_m[a_addr], a_din, a_be);
`ifdef BRAM_TDP_COLLISION_DETECT_EN
            exp_coll = a_en && b_en && (a_addr == b_addr) && (a_wr || b_wr);
            if (exp_coll && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
        end
    end

    // Monitor: pops the scoreboard on every valid strobe, checks hold otherwise
    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            for (int d = 0; d < ND; d++)
                for (int p = 0; p < 2; p++) begin
                    if (vld[d][p]) begin
                        if (q[d][p].size() == 0) begin
                            chk(1'b0, $sformatf("spurious_valid i%0d p%0d", d, p), 32'd1, 32'd0);
                        end else begin
                            e = q[d][p].pop_front();
                            chk(e.due == cyc, $sformatf("valid_cycle i%0d p%0d", d, p), cyc, e.due);
                            chk(dout[d][p] === e.d, $sformatf("dout i%0d p%0d", d, p), dout[d][p], e.d);
                            last[d][p] = e.d;
                        end
                    end else begin
                        if (q[d][p].size() > 0 && q[d][p][0].due <= cyc) begin
                            e = q[d][p].pop_front();
                            chk(1'b0, $sformatf("missing_valid i%0d p%0d", d, p), 32'd0, e.d);
                        end
                        chk(dout[d][p] === last[d][p], $sformatf("hold i%0d p%0d", d, p),
                            dout[d][p], last[d][p]);
                    end
                end
`ifdef BRAM_TDP_COLLISION_DETECT_EN
            chk(c0 === exp_coll && c1 === exp_coll && c2 === exp_coll, "collision",
                {29'd0, c2, c1, c0}, {29'd0, {3{exp_coll}}});
            chk(k0 === exp_cnt && k1 === exp_cnt && k2 === exp_cnt, "collision_count",
                {16'd0, k0}, {16'd0, exp_cnt});
`endif
        end
    end

    task automatic step(input logic ae, input logic aw, input logic [3:0] abe, input logic [3:0] aad,
                        input logic [31:0] ad, input logic be_, input logic bw, input logic [3:0] bbe,
                        input logic [3:0] bad, input logic [31:0] bd);
        a_en = ae; a_wr = aw; a_be = abe; a_addr = aad; a_din = ad;
        b_en = be_; b_wr = bw; b_be = bbe; b_addr = bad; b_din = bd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'h0, 4'h0, '0, 0, 0, 4'h0, 4'h0, '0);
    endtask

    initial begin
        logic [31:0] pre;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Known contents everywhere; addr 5 = 11223344, addrs 7 and 9 = 0
        for (int a = 0; a < 16; a++) begin
            pre = (a == 5) ? 32'h11223344 : (a == 7 || a == 9) ? 32'h0 : $urandom;
            step(1, 1, 4'hF, 4'(a), pre, 0, 0, 4'h0, 4'h0, '0);
        end
        idle(2);

        // Basic write then cross-port read
        step(1, 1, 4'hF, 4'd3, 32'hDEADBEEF, 0, 0, 4'h0, 4'h0, '0);
        step(0, 0, 4'h0, 4'h0, '0, 1, 0, 4'h0, 4'd3, '0);
        idle(2);
        // Byte-enable merge, read back on both ports
        step(1, 1, 4'b0101, 4'd5, 32'hAABBCCDD, 0, 0, 4'h0, 4'h0, '0);
        step(1, 0, 4'h0, 4'd5, '0, 1, 0, 4'h0, 4'd5, '0);
        idle(2);
        // Single-port write-mode behaviour
        step(1, 1, 4'hF, 4'd7, 32'h5A5A5A5A, 0, 0, 4'h0, 4'h0, '0);
        idle(2);
        // Dual write to one address, then read
        step(1, 1, 4'h3, 4'd2, 32'h1, 1, 1, 4'hF, 4'd2, 32'hFFFFFFFF);
        step(1, 0, 4'h0, 4'd2, '0, 0, 0, 4'h0, 4'h0, '0);
        idle(2);
        // Read during write from the other port, then read again
        step(1, 1, 4'hF, 4'd9, 32'h77, 1, 0, 4'h0, 4'd9, '0);
        step(0, 0, 4'h0, 4'h0, '0, 1, 0, 4'h0, 4'd9, '0);
        idle(2);
        // Read followed by reset on the next edge; contents must survive
        step(1, 0, 4'h0, 4'd3, '0, 1, 0, 4'h0, 4'd5, '0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        step(1, 0, 4'h0, 4'd3, '0, 1, 0, 4'h0, 4'd5, '0);
        idle(3);

        // Random traffic, narrow address range to provoke collisions
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom_range(0, 3)),
                 $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom_range(0, 3)),
                 $urandom);
        end
        rst = 1'b0;
        idle(6);

        for (int d = 0; d < ND; d++)
            for (int p = 0; p < 2; p++)
                chk(q[d][p].size() == 0, $sformatf("drained i%0d p%0d", d, p), q[d][p].size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/bram_sync_tdp.md
Name: bram_sync_tdp

Overview:
- Parameterised, synchronous, true dual-port block RAM on a single clock. It succeeds the single-port BRAM primitive.
- Adds two independent read/write ports, per-byte write enables, selectable write mode, configurable read latency and a read-valid strobe.
- Used as a shared buffer between two datapath agents in the same clock domain, e.g. a packet buffer with one producer port and one consumer port.

Parameters:
- RAM_DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- RAM_ADDR_WIDTH, 4: address width; depth = 2**RAM_ADDR_WIDTH words.
- RD_LATENCY, 1: read latency in cycles; legal values 1 or 2. 2 adds an output register stage.
- WRITE_MODE, "READ_FIRST": dout behaviour on a write. Legal values "READ_FIRST", "WRITE_FIRST", "NO_CHANGE". Applies to both ports.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a_en  in  1  port A access enable.
- a_wr  in  1  port A write (qualified by a_en).
- a_be  in  RAM_DATA_WIDTH/8  port A byte write enables; bit i enables byte [8i+7:8i].
- a_addr  in  RAM_ADDR_WIDTH  port A address.
- a_din  in  RAM_DATA_WIDTH  port A write data.
- a_dout  out  RAM_DATA_WIDTH  port A read data.
- a_valid  out  1  port A dout-updated strobe.
- b_en, b_wr, b_be, b_addr, b_din, b_dout, b_valid: identical to the port A signals, for port B.

Behaviour:
- Reset (rst=1):
  - a_dout, b_dout go to 0; a_valid, b_valid go to 0.
  - All read pipeline stages are flushed to 0 and invalid.
  - Writes are suppressed while rst=1.
  - Memory contents are not cleared.
- Access on a port: a_en=1 at edge N.
  - Write: a_wr=1 and a_be != 0 updates only the enabled bytes of mem[a_addr] at edge N.
  - A write with a_be=0 is treated as a read for dout purposes.
- Read: a_en=1, a_wr=0 at edge N.
  - RD_LATENCY=1: a_dout = mem[a_addr] and a_valid=1 after edge N.
  - RD_LATENCY=2: same, after edge N+1.
- Write-mode effect on dout when a write is accepted:
  - READ_FIRST: dout gets the pre-write word.
  - WRITE_FIRST: dout gets the post-write merged word, i.e. enabled bytes from din, others from old data.
  - NO_CHANGE: dout holds its value and valid stays 0 for that access.
- a_valid: single-cycle strobe, aligned with every dout update. Otherwise 0.
- dout holds its last value when there is no update.
- a_en=0: no memory effect. The pipeline advances with an invalid slot.
- Pipeline cadence:
  - Back-to-back accesses every cycle are supported.
  - Throughput is 1 access per port per cycle.
  - There is no stall or backpressure.
- Cross-port collisions (same address, same edge):
  - Both ports write: port A wins on bytes enabled on both ports. Bytes enabled on only one port take that port's data.
  - One port writes, the other reads: the reader gets the pre-write word, whatever WRITE_MODE is.
  - Both ports read: both get the same word.
- Reset mid-operation: reads in flight at the rst edge are discarded. No valid strobe is produced for them.
- Illegal parameters (RD_LATENCY not in {1,2}, WRITE_MODE unknown, width not a multiple of 8): elaboration-time error via a generate-block check.

Optional Feature:
- Macro: BRAM_TDP_COLLISION_DETECT_EN.
- When defined, the block adds an output port collision (1 bit).
  - collision pulses high for one cycle, the cycle after an edge where a_en & b_en & (a_addr==b_addr) & (a_wr | b_wr) and rst=0.
  - Also adds collision_count out [15:0], saturating at 16'hFFFF and cleared by rst.
- When not defined: neither port exists, no detection logic is built, and the collision resolution rules above still apply.

Test Plan:
1. Basic read/write, RD_LATENCY=1. Write A addr 3 = 32'hDEADBEEF with be=4'hF, then read B addr 3. Required: b_dout=32'hDEADBEEF and b_valid=1 one cycle after the read edge.
2. Byte enables and latency. Preload addr 5 = 32'h11223344. Write A with be=4'b0101, din=32'hAABBCCDD, then read addr 5. Required: 32'h11BB33DD, appearing 2 cycles after the read with RD_LATENCY=2.
3. Write modes, single port. Write addr 7, old=32'h0, new=32'h5A5A5A5A.
   - READ_FIRST: a_dout=0 and a_valid=1.
   - WRITE_FIRST: a_dout=32'h5A5A5A5A and a_valid=1.
   - NO_CHANGE: a_dout unchanged and a_valid=0.
4. Dual-write collision. Same edge: A writes addr 2 = 32'h1 with be=4'h3; B writes addr 2 = 32'hFFFFFFFF with be=4'hF. A following read of addr 2 returns 32'hFFFF0001. With the macro defined, collision=1 for one cycle and collision_count=1.
5. Read/write collision. A writes addr 9 = 32'h77 while B reads addr 9 (old 32'h0). Required: b_dout=0, and a subsequent B read returns 32'h77.
6. Reset mid-flight, RD_LATENCY=2. Issue a read, then assert rst on the next edge. Required: no valid strobe, both douts=0, and memory contents preserved (a read after reset returns the previously written data).
